// File: rtl/dom_share_codec_pkg.sv
// rtl/dom_share_codec_pkg.sv - shared constants and types for the share codec
package dom_codec_pkg;

    localparam int SHARES    = 2;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 16;

    // Share pair at the default width; share0 sits in the upper half
    typedef struct packed {
        logic [DEF_WIDTH-1:0] share0;
        logic [DEF_WIDTH-1:0] share1;
    } share_pair_t;

endpackage

// File: rtl/dom_share_codec_if.sv
// rtl/dom_share_codec_if.sv - encoder/decoder handshake bundle for the share codec
interface dom_share_codec_if
    import dom_codec_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             enc_in_valid;
    logic             enc_in_ready;
    logic [WIDTH-1:0] enc_in_data;
    logic [WIDTH-1:0] enc_in_rand;
    logic             enc_out_valid;
    logic             enc_out_ready;
    logic [WIDTH-1:0] enc_out_share0;
    logic [WIDTH-1:0] enc_out_share1;
    logic             dec_in_valid;
    logic             dec_in_ready;
    logic [WIDTH-1:0] dec_in_share0;
    logic [WIDTH-1:0] dec_in_share1;
    logic             dec_out_valid;
    logic             dec_out_ready;
    logic [WIDTH-1:0] dec_out_data;

    // Master drives words/shares in and accepts results
    modport master (
        output enc_in_valid, enc_in_data, enc_in_rand, enc_out_ready,
        output dec_in_valid, dec_in_share0, dec_in_share1, dec_out_ready,
        input  enc_in_ready, enc_out_valid, enc_out_share0, enc_out_share1,
        input  dec_in_ready, dec_out_valid, dec_out_data
    );

    // Slave is the codec itself
    modport slave (
        input  enc_in_valid, enc_in_data, enc_in_rand, enc_out_ready,
        input  dec_in_valid, dec_in_share0, dec_in_share1, dec_out_ready,
        output enc_in_ready, enc_out_valid, enc_out_share0, enc_out_share1,
        output dec_in_ready, dec_out_valid, dec_out_data
    );
endinterface

// File: rtl/dom_share_codec_stage.sv
// rtl/dom_share_codec_stage.sv - valid/ready register slice with full throughput
module dom_share_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);
    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;
    logic         load;

    // Load when empty or draining this cycle; hold contents otherwise
    always_comb begin
        in_ready_o = !valid_q || out_ready_i;
        load       = in_valid_i && in_ready_o;
        valid_d    = valid_q;
        data_d     = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = in_data_i;
        end else if (out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    // Slice register; reset empties the slice and clears the payload
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
endmodule

// File: rtl/dom_share_codec.sv
// rtl/dom_share_codec.sv - Boolean masking encoder and registered share recombiner
module dom_share_codec
    import dom_codec_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    dom_share_codec_if.slave  bus,
    output logic [CNT_W-1:0]  enc_count,
    output logic [CNT_W-1:0]  dec_count
);
    localparam int PW = SHARES * WIDTH;

    logic          enc_ready;
    logic [PW-1:0] enc_pair;
    logic          dec_ready;
    logic          s1_valid;
    logic [PW-1:0] s1_pair;
    logic          s2_can_load;
    logic [WIDTH-1:0] s1_recombined;
    logic [CNT_W-1:0] enc_cnt_q, enc_cnt_d;
    logic [CNT_W-1:0] dec_cnt_q, dec_cnt_d;

    // Encoder: mask is applied ahead of the only register, so outputs are pure flops
    dom_share_stage #(.W(PW)) u_enc (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (bus.enc_in_valid),
        .in_ready_o  (enc_ready),
        .in_data_i   ({bus.enc_in_data ^ bus.enc_in_rand, bus.enc_in_rand}),
        .out_valid_o (bus.enc_out_valid),
        .out_ready_i (bus.enc_out_ready),
        .out_data_o  (enc_pair)
    );

    // Decoder S1: shares are registered side by side, never combined before this edge
    dom_share_stage #(.W(PW)) u_dec_s1 (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (bus.dec_in_valid),
        .in_ready_o  (dec_ready),
        .in_data_i   ({bus.dec_in_share0, bus.dec_in_share1}),
        .out_valid_o (s1_valid),
        .out_ready_i (s2_can_load),
        .out_data_o  (s1_pair)
    );

    assign s1_recombined = s1_pair[PW-1:WIDTH] ^ s1_pair[WIDTH-1:0];

    // Decoder S2: recombination only ever sees glitch-free registered shares
    dom_share_stage #(.W(WIDTH)) u_dec_s2 (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (s1_valid),
        .in_ready_o  (s2_can_load),
        .in_data_i   (s1_recombined),
        .out_valid_o (bus.dec_out_valid),
        .out_ready_i (bus.dec_out_ready),
        .out_data_o  (bus.dec_out_data)
    );

    // Readys are forced low while reset is held so every output reads 0
    assign bus.enc_in_ready   = enc_ready && !rst;
    assign bus.dec_in_ready   = dec_ready && !rst;
    assign bus.enc_out_share0 = enc_pair[PW-1:WIDTH];
    assign bus.enc_out_share1 = enc_pair[WIDTH-1:0];

    // Completed output transfers, wrapping naturally at the counter width
    always_comb begin
        enc_cnt_d = enc_cnt_q;
        dec_cnt_d = dec_cnt_q;
        if (bus.enc_out_valid && bus.enc_out_ready) enc_cnt_d = enc_cnt_q + 1'b1;
        if (bus.dec_out_valid && bus.dec_out_ready) dec_cnt_d = dec_cnt_q + 1'b1;
    end

    // Counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enc_cnt_q <= '0;
            dec_cnt_q <= '0;
        end else begin
            enc_cnt_q <= enc_cnt_d;
            dec_cnt_q <= dec_cnt_d;
        end
    end

    assign enc_count = enc_cnt_q;
    assign dec_count = dec_cnt_q;
endmodule
